// File: rtl/player_motion.sv
// rtl/player_motion.sv - per-frame player position: walk, squat, parabolic jump, dash with cooldown.
// Optional air jump is enabled by defining PLAYER_DOUBLE_JUMP_EN.
module player_motion #(
    parameter int X_W       = 11,
    parameter int Y_W       = 10,
    parameter int MAP_X     = 320,
    parameter int MAP_Y     = 240,
    parameter int PLAYER_X  = 32,
    parameter int LIMIT_X   = 600,
    parameter int PLAYER_Y  = 48,
    parameter int SQUAT_Y   = 32,
    parameter int STEP_X    = 4,
    parameter int V         = 20,
    parameter int G         = 2,
    parameter int MAX_J     = 15,
    parameter int DASH_STEP = 12,
    parameter int DASH_LEN  = 4,
    parameter int DASH_CD   = 30
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  right,
    input  logic                  left,
    input  logic                  jump,
    input  logic                  squat,
    input  logic                  defend,
    input  logic                  dash,
    output logic signed [X_W-1:0] x,
    output logic signed [Y_W-1:0] y,
    output logic                  isD,
    output logic                  isQ,
    output logic                  isJ,
    output logic                  isDash,
    output logic                  facing
);

    localparam int AW  = 2 * Y_W;
    localparam int XW2 = X_W + 2;
    localparam int KW  = $clog2(MAX_J + 2);
    localparam int DLW = $clog2(DASH_LEN + 1);
    localparam int CDW = $clog2(DASH_CD + 1);

    localparam logic signed [Y_W-1:0] Y_BASE   = Y_W'(PLAYER_Y - MAP_Y);
    localparam logic signed [Y_W-1:0] Y_SQUAT  = Y_W'(SQUAT_Y - MAP_Y);
    localparam logic signed [AW-1:0]  Y_BASE_E = AW'(PLAYER_Y - MAP_Y);
    localparam logic signed [AW-1:0]  V_S      = AW'(V);
    localparam logic signed [AW-1:0]  G_S      = AW'(G);
    localparam logic signed [X_W-1:0] X_MIN    = X_W'(PLAYER_X - MAP_X);
    localparam logic signed [XW2-1:0] X_MIN_E  = XW2'(PLAYER_X - MAP_X);
    localparam logic signed [XW2-1:0] X_MAX_E  = XW2'(LIMIT_X - MAP_X);
    localparam logic signed [XW2-1:0] STEP_E   = XW2'(STEP_X);
    localparam logic signed [XW2-1:0] DSTEP_E  = XW2'(DASH_STEP);

    typedef enum logic [1:0] {GROUND, SQUAT, AIR} vstate_t;

    vstate_t               state_q, state_d;
    logic signed [Y_W-1:0] y_q, y0_q, y_air;
    logic [KW-1:0]         k_q;
    logic signed [X_W-1:0] x_q, x_d;
    logic                  facing_q, facing_d;
    logic                  jump_q, dash_q;
    logic [DLW-1:0]        dash_cnt_q;
    logic [CDW-1:0]        cd_q;
    logic                  jump_edge, dash_edge, dashing, dash_start;
    logic                  launch, land, air_jump;

    logic signed [AW-1:0]  kk, y0_e, y_full;
    logic signed [XW2-1:0] x_e, delta, x_sum;

    assign jump_edge  = jump & ~jump_q;
    assign dash_edge  = dash & ~dash_q;
    assign dashing    = (dash_cnt_q != '0);
    assign dash_start = dash_edge & ~dashing & (cd_q == '0);

`ifdef PLAYER_DOUBLE_JUMP_EN
    logic air_used_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            air_used_q <= 1'b0;
        end else if (tick) begin
            if (land)
                air_used_q <= 1'b0;
            else if (air_jump)
                air_used_q <= 1'b1;
        end
    end
`endif

    // vertical FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= GROUND;
        else if (tick)
            state_q <= state_d;
    end

    // vertical FSM: next state; a jump edge beats squat, landing beats an air jump
    always_comb begin
        state_d  = state_q;
        launch   = 1'b0;
        land     = 1'b0;
        air_jump = 1'b0;
        case (state_q)
            GROUND, SQUAT: begin
                if (jump_edge) begin
                    state_d = AIR;
                    launch  = 1'b1;
                end else if (squat) begin
                    state_d = SQUAT;
                end else begin
                    state_d = GROUND;
                end
            end
            AIR: begin
                if (k_q == KW'(MAX_J)) begin
                    state_d = GROUND;
                    land    = 1'b1;
                end
`ifdef PLAYER_DOUBLE_JUMP_EN
                else if (jump_edge && !air_used_q) begin
                    air_jump = 1'b1;
                end
`endif
            end
            default: state_d = GROUND;
        endcase
    end

    // vertical FSM: outputs
    always_comb begin
        isJ = (state_q == AIR);
        isQ = (state_q == SQUAT);
    end

    // y = y0 + V*k - G*k^2/2 in double-width signed math, floored at standing height
    always_comb begin
        kk     = {{(AW-KW){1'b0}}, k_q};
        y0_e   = {{(AW-Y_W){y0_q[Y_W-1]}}, y0_q};
        y_full = y0_e + V_S * kk - ((G_S * kk * kk) >>> 1);
        if (y_full < Y_BASE_E)
            y_air = Y_BASE;
        else
            y_air = y_full[Y_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q  <= Y_BASE;
            y0_q <= Y_BASE;
            k_q  <= '0;
        end else if (tick) begin
            if (state_q == AIR) begin
                if (air_jump) begin
                    y0_q <= y_q;
                    k_q  <= '0;
                end else begin
                    y_q <= y_air;
                    k_q <= land ? '0 : k_q + KW'(1);
                end
            end else if (launch) begin
                y_q  <= Y_BASE;
                y0_q <= Y_BASE;
                k_q  <= '0;
            end else begin
                y_q <= squat ? Y_SQUAT : Y_BASE;
            end
        end
    end

    // horizontal step: dash overrides walk and freezes facing
    always_comb begin
        x_e      = {{(XW2-X_W){x_q[X_W-1]}}, x_q};
        delta    = '0;
        facing_d = facing_q;
        if (dashing) begin
            delta = facing_q ? DSTEP_E : -DSTEP_E;
        end else if (right) begin
            delta    = STEP_E;
            facing_d = 1'b1;
        end else if (left) begin
            delta    = -STEP_E;
            facing_d = 1'b0;
        end
        x_sum = x_e + delta;
        if (x_sum < X_MIN_E)
            x_d = X_MIN_E[X_W-1:0];
        else if (x_sum > X_MAX_E)
            x_d = X_MAX_E[X_W-1:0];
        else
            x_d = x_sum[X_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q        <= X_MIN;
            facing_q   <= 1'b1;
            jump_q     <= 1'b0;
            dash_q     <= 1'b0;
            dash_cnt_q <= '0;
            cd_q       <= '0;
        end else if (tick) begin
            x_q      <= x_d;
            facing_q <= facing_d;
            jump_q   <= jump;
            dash_q   <= dash;
            if (dashing) begin
                dash_cnt_q <= dash_cnt_q - DLW'(1);
                if (dash_cnt_q == DLW'(1))
                    cd_q <= CDW'(DASH_CD);
            end else begin
                if (cd_q != '0)
                    cd_q <= cd_q - CDW'(1);
                if (dash_start)
                    dash_cnt_q <= DLW'(DASH_LEN);
            end
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign facing = facing_q;
    assign isDash = dashing;
    assign isD    = defend & ~dashing;

endmodule
